// File: rtl/vending_pkg.sv
// vending_pkg: shared state encoding and coin constants for the vending controller
package vending_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, REFUND} state_t;
  localparam int CASH_W = 7;
  localparam logic [7:0] COIN_1_VAL = 8'd1;
  localparam logic [7:0] COIN_5_VAL = 8'd5;
  localparam logic [7:0] COIN_10_VAL = 8'd10;
endpackage

// File: rtl/vending_controller_tick_timer.sv
// tick_timer: restartable counter that pulses done when it reaches last, then wraps to 0
module tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         done
);
  logic [W-1:0] cnt;
  assign done = en && cnt == last;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear || done) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/vending_controller.sv
// vending_controller: credit tracking, dispense sequencing and coin-by-coin change return
module vending_controller
  import vending_pkg::*;
#(
  parameter int PRICE = 25,
  parameter int MAX_CASH = 99,
  parameter int DISPENSE_CYCLES = 50000000,
  parameter int REFUND_STEP_CYCLES = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coin_1,
  input  logic              coin_5,
  input  logic              coin_10,
  input  logic              select,
  input  logic              cancel,
  output logic [CASH_W-1:0] cash,
  output logic              refund,
  output logic              dispense,
  output logic              change_pulse,
  output logic              coin_reject,
  output logic              insufficient,
  output logic              busy
);
  localparam int TMAX = DISPENSE_CYCLES > REFUND_STEP_CYCLES ? DISPENSE_CYCLES : REFUND_STEP_CYCLES;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam logic [7:0] PRICE8 = 8'(PRICE);
  localparam logic [7:0] MAX8 = 8'(MAX_CASH);
  state_t state, ns;
  logic [CASH_W-1:0] ncash;
  logic [7:0] sum, total;
  logic any_coin, chg, rej, ins, done, active;
  logic [TW-1:0] last;
  assign sum = (coin_1 ? COIN_1_VAL : 8'd0) + (coin_5 ? COIN_5_VAL : 8'd0) + (coin_10 ? COIN_10_VAL : 8'd0);
  assign total = {1'b0, cash} + sum;
  assign any_coin = coin_1 | coin_5 | coin_10;
  assign active = state == DISPENSE || state == REFUND;
  assign last = state == DISPENSE ? TW'(DISPENSE_CYCLES - 1) : TW'(REFUND_STEP_CYCLES - 1);
  always_comb begin
    ns = state;
    ncash = cash;
    chg = 1'b0;
    rej = 1'b0;
    ins = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        if (cancel && cash != '0) begin
          ns = REFUND;
          rej = any_coin;
        end else if (select && {1'b0, cash} >= PRICE8) begin
          ns = DISPENSE;
          ncash = CASH_W'({1'b0, cash} - PRICE8);
          rej = any_coin;
        end else begin
          ins = select;
          rej = any_coin && total > MAX8;
          ncash = total > MAX8 ? cash : CASH_W'(total);
          ns = ncash == '0 ? IDLE : COLLECT;
        end
      end
      DISPENSE: begin
        rej = any_coin;
        ns = done ? (cash != '0 ? REFUND : IDLE) : DISPENSE;
      end
      default: begin
        rej = any_coin;
        chg = cash != '0 && done;
        ncash = chg ? cash - 1'b1 : cash;
        ns = cash == '0 ? IDLE : REFUND;
      end
    endcase
  end
  // timer restarts on every state entry and after each returned unit
  tick_timer #(.W(TW)) u_timer (
    .clk(clk), .rst(rst), .clear(ns != state || chg), .en(active), .last(last), .done(done)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cash <= '0;
      refund <= 1'b0;
      dispense <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject <= 1'b0;
      insufficient <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= ns;
      cash <= ncash;
      refund <= ns == REFUND && ncash != '0;
      dispense <= ns == DISPENSE;
      change_pulse <= chg;
      coin_reject <= rej;
      insufficient <= ins;
      busy <= ns == DISPENSE || ns == REFUND;
    end
endmodule

// File: tb/tb_vending_controller.sv
// tb_vending_controller: table-driven and scoreboard check of vending_controller
module tb_vending_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic coin_1 = 1'b0, coin_5 = 1'b0, coin_10 = 1'b0, select = 1'b0, cancel = 1'b0;
  logic [6:0] cash;
  logic refund, dispense, change_pulse, coin_reject, insufficient, busy;
  int tests = 0, fails = 0;

  localparam logic [4:0] N = 5'b00000, C1 = 5'b10000, C5 = 5'b01000, C10 = 5'b00100;
  localparam logic [4:0] SEL = 5'b00010, CAN = 5'b00001;
  localparam logic [5:0] F0 = 6'b000000, RF = 6'b100000, DP = 6'b010000, CH = 6'b001000;
  localparam logic [5:0] RJ = 6'b000100, IN = 6'b000010, BS = 6'b000001;

  typedef struct packed {
    logic [4:0]  in;
    logic [12:0] ex;
  } vec_t;

  vec_t tbl[$];
  logic [12:0] exp_q[$];

  vending_controller #(.PRICE(25), .MAX_CASH(99), .DISPENSE_CYCLES(4), .REFUND_STEP_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .coin_1(coin_1), .coin_5(coin_5), .coin_10(coin_10),
    .select(select), .cancel(cancel), .cash(cash), .refund(refund), .dispense(dispense),
    .change_pulse(change_pulse), .coin_reject(coin_reject), .insufficient(insufficient), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic [4:0] in, input logic [6:0] c, input logic [5:0] f);
    vec_t r;
    r.in = in;
    r.ex = {c, f};
    return r;
  endfunction

  function automatic logic [12:0] outs();
    return {cash, refund, dispense, change_pulse, coin_reject, insufficient, busy};
  endfunction

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got cash=%0d rf/dp/ch/rj/in/bs=%b, expected cash=%0d rf/dp/ch/rj/in/bs=%b",
               name, got[12:6], got[5:0], want[12:6], want[5:0]);
    end
  endtask

  task automatic cyc(input string name, input logic [4:0] in, input logic [6:0] c, input logic [5:0] f);
    {coin_1, coin_5, coin_10, select, cancel} = in;
    exp_q.push_back({c, f});
    @(posedge clk);
    #1;
    {coin_1, coin_5, coin_10, select, cancel} = N;
    check(name, outs(), exp_q.pop_front());
  endtask

  initial begin
    tbl.push_back(v(CAN, 0, F0));
    tbl.push_back(v(SEL, 0, IN));
    tbl.push_back(v(C10, 10, F0));
    tbl.push_back(v(C10, 20, F0));
    tbl.push_back(v(SEL, 20, IN));
    tbl.push_back(v(C5, 25, F0));
    tbl.push_back(v(SEL, 0, DP | BS));
    for (int i = 0; i < 3; i++) tbl.push_back(v(N, 0, DP | BS));
    tbl.push_back(v(N, 0, F0));
    tbl.push_back(v(N, 0, F0));
    tbl.push_back(v(C10, 10, F0));
    tbl.push_back(v(C10, 20, F0));
    tbl.push_back(v(C5, 25, F0));
    tbl.push_back(v(C1, 26, F0));
    tbl.push_back(v(C1, 27, F0));
    tbl.push_back(v(SEL, 2, DP | BS));
    for (int i = 0; i < 3; i++) tbl.push_back(v(N, 2, DP | BS));
    for (int i = 0; i < 3; i++) tbl.push_back(v(N, 2, RF | BS));
    tbl.push_back(v(N, 1, RF | CH | BS));
    for (int i = 0; i < 2; i++) tbl.push_back(v(N, 1, RF | BS));
    tbl.push_back(v(N, 0, CH | BS));
    tbl.push_back(v(N, 0, F0));
    tbl.push_back(v(C10, 10, F0));
    tbl.push_back(v(C10, 20, F0));
    tbl.push_back(v(C5, 25, F0));
    tbl.push_back(v(SEL, 0, DP | BS));
    tbl.push_back(v(C10 | SEL, 0, DP | BS | RJ));
    for (int i = 0; i < 2; i++) tbl.push_back(v(N, 0, DP | BS));
    tbl.push_back(v(N, 0, F0));
    tbl.push_back(v(N, 0, F0));
    tbl.push_back(v(C5 | SEL, 5, IN));
    tbl.push_back(v(N, 5, F0));

    @(posedge clk);
    #1;
    check("reset_state", outs(), 13'd0);
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) cyc($sformatf("vec%0d", i), tbl[i].in, tbl[i].ex[12:6], tbl[i].ex[5:0]);

    cyc("prio_c1", C10, 15, F0);
    cyc("prio_c2", C10, 25, F0);
    cyc("prio_c3", C5, 30, F0);
    cyc("prio_all", SEL | CAN | C5, 30, RF | RJ | BS);
    cyc("prio_hold", N, 30, RF | BS);
    rst = 1'b1;
    #1;
    check("prio_rst_async", outs(), 13'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("prio_rst_cycle", outs(), 13'd0);

    cyc("rf7_c1", C5, 5, F0);
    cyc("rf7_c2", C1, 6, F0);
    cyc("rf7_c3", C1, 7, F0);
    cyc("rf7_cancel", CAN, 7, RF | BS);
    cyc("rf7_w1", N, 7, RF | BS);
    cyc("rf7_w2", N, 7, RF | BS);
    cyc("rf7_step", N, 6, RF | CH | BS);
    cyc("rf7_w3", N, 6, RF | BS);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rf7_rst", outs(), 13'd0);
    rst = 1'b0;
    cyc("rf7_idle", C1, 1, F0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("sat_rst", outs(), 13'd0);

    for (int i = 1; i <= 5; i++) cyc($sformatf("sat_add%0d", i), C1 | C5 | C10, 7'(16 * i), F0);
    cyc("sat_90", C10, 90, F0);
    cyc("sat_95", C5, 95, F0);
    cyc("sat_rej5", C5, 95, RJ);
    cyc("sat_rej6", C1 | C5, 95, RJ);
    cyc("sat_96", C1, 96, F0);
    cyc("sat_rej16", C1 | C5 | C10, 96, RJ);
    cyc("sat_hold", N, 96, F0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
